kbd_autotype_ctrl: RTL and testbench

Scheduler that types queued key events into the 12x7 keyboard matrix. The matrix is shared between the PS/2 decoder (physical keys) and this injector (paste/autotype from the OSD or a loader).
- Events are buffered in an internal FIFO.
- Each event is sequenced through shift-setup, press-hold and release-gap phases, timed in scan ticks.
- The result is an active-low overlay mask, ANDed per bit with the physical matrix before the address decode.

---
 rtl/kbd_autotype_if.sv | 24 ++
 rtl/kbd_autotype_ctrl.sv | 135 +++++++++++++
 tb/tb_kbd_autotype_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/kbd_autotype_if.sv
// Event-injection and overlay bundle between a loader/OSD (master) and kbd_autotype_ctrl (slave).
interface kbd_autotype_if;
  logic        tick;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clear;
  logic        phys_active;
  logic [83:0] mask;
  logic        full;
  logic        empty;
  logic        busy;
  logic        overflow;
  logic        bad_event;

  modport master (
    output tick, wr_en, wr_data, clear, phys_active,
    input  mask, full, empty, busy, overflow, bad_event
  );

  modport slave (
    input  tick, wr_en, wr_data, clear, phys_active,
    output mask, full, empty, busy, overflow, bad_event
  );
endinterface

// File: rtl/kbd_autotype_ctrl.sv
// Autotype scheduler: FIFO of key events sequenced into an active-low 12x7 matrix overlay.
// Define AUTOTYPE_PHYS_PRIORITY_EN to stall injection while a physical key is down.
module kbd_autotype_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_TICKS  = 3,
  parameter int GAP_TICKS   = 2,
  parameter int SHIFT_TICKS = 1
) (
  input logic           clk,
  input logic           reset,
  kbd_autotype_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] GAP_L   = CW'(GAP_TICKS);
  localparam logic [CW-1:0] SHIFT_L = CW'(SHIFT_TICKS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PRESS = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    hold;
  logic [7:0]    head;
  logic          pause, pop, push, head_valid, step, last;
  logic [6:0]    key_idx;
  logic [83:0]   mask_next;

`ifdef AUTOTYPE_PHYS_PRIORITY_EN
  assign pause = bus.phys_active;
`else
  logic unused_phys;
  assign pause       = 1'b0;
  assign unused_phys = bus.phys_active;
`endif

  assign bus.full  = (count == DEPTH_L);
  assign bus.empty = (count == '0);
  assign bus.busy  = (state != S_IDLE) || !bus.empty;

  assign head       = mem[rd_ptr];
  assign head_valid = (head[6:3] <= 4'd11) && (head[2:0] != 3'd7);
  assign pop        = (state == S_IDLE) && !bus.empty && !pause && !bus.clear;
  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign push       = bus.wr_en && (!bus.full || pop) && !bus.clear;
  assign step       = bus.tick && !pause;
  assign last       = (cnt == CW'(1));
  assign key_idx    = 7'(hold[6:3]) * 7'd7 + 7'(hold[2:0]);

  always_comb begin
    mask_next = '1;
    case (state)
      S_SHIFT: mask_next[6] = 1'b0;
      S_PRESS: begin
        mask_next[key_idx] = 1'b0;
        if (hold[7]) mask_next[6] = 1'b0;
      end
      default: mask_next = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      hold          <= '0;
      bus.mask      <= '1;
      bus.overflow  <= 1'b0;
      bus.bad_event <= 1'b0;
    end else begin
      bus.overflow  <= bus.wr_en && bus.full && !pop && !bus.clear;
      bus.bad_event <= pop && !head_valid;
      bus.mask      <= bus.clear ? '1 : mask_next;
      if (bus.clear) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: if (pop) begin
            hold <= head;
            if (head_valid) begin
              state <= head[7] ? S_SHIFT : S_PRESS;
              cnt   <= head[7] ? SHIFT_L : HOLD_L;
            end
          end
          S_SHIFT: if (step) begin
            if (last) begin
              state <= S_PRESS;
              cnt   <= HOLD_L;
            end else cnt <= cnt - 1'b1;
          end
          S_PRESS: if (step) begin
            if (last) begin
              state <= S_GAP;
              cnt   <= GAP_L;
            end else cnt <= cnt - 1'b1;
          end
          default: if (step) begin
            if (last) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else cnt <= cnt - 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_kbd_autotype_ctrl.sv
// Directed bench for kbd_autotype_ctrl with default parameters (HOLD=3, GAP=2, SHIFT=1, depth 16).
module tb_kbd_autotype_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  kbd_autotype_if bus ();

  kbd_autotype_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [83:0] ALL1 = '1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [83:0] key_mask(input logic [7:0] ev);
    logic [83:0] m;
    m = '1;
    m[int'(ev[6:3]) * 7 + int'(ev[2:0])] = 1'b0;
    if (ev[7]) m[6] = 1'b0;
    return m;
  endfunction

  // Waits for the key to appear, checks its mask and optionally its hold length.
  task automatic type_key(input logic [7:0] ev, input bit chk_len, input string tag);
    logic [83:0] exp;
    int unsigned n;
    exp = key_mask(ev);
    n = 0;
    while (bus.mask === ALL1 && n < 60) begin step(); n++; end
    chk({tag, " press"}, bus.mask, exp);
    n = 0;
    while (bus.mask === exp && n < 60) begin step(); n++; end
    if (chk_len) chk({tag, " hold_len"}, 84'(n), 84'(3));
    chk({tag, " release"}, bus.mask, ALL1);
  endtask

  logic [7:0]  evs [18];
  logic [83:0] exp;
  bit          ok;

  initial begin
    reset           = 1'b1;
    bus.tick        = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_data     = '0;
    bus.clear       = 1'b0;
    bus.phys_active = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state held through idle cycles
    repeat (10) step();
    chk("rst mask", bus.mask, ALL1);
    chk("rst empty", bus.empty, 1'b1);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst full", bus.full, 1'b0);
    chk("rst ovf", bus.overflow, 1'b0);
    chk("rst bad", bus.bad_event, 1'b0);

    // Unshifted key 0x0D: bit 12 low 3 cycles, 2 gap cycles, then idle
    bus.tick = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 8'h0D;
    step();
    bus.wr_en = 1'b0;
    chk("a busy", bus.busy, 1'b1);
    step();
    chk("a pop mask", bus.mask, ALL1);
    type_key(8'h0D, 1'b1, "a");
    chk("a gap busy", bus.busy, 1'b1);
    step();
    chk("a gap2 mask", bus.mask, ALL1);
    chk("a idle busy", bus.busy, 1'b0);

    // Shifted key 0x8D: shift alone 1 cycle, then shift+key 3 cycles
    bus.wr_en = 1'b1; bus.wr_data = 8'h8D;
    step();
    bus.wr_en = 1'b0;
    step();
    chk("s pop mask", bus.mask, ALL1);
    step();
    exp = ALL1; exp[6] = 1'b0;
    chk("s shift only", bus.mask, exp);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s shift+key", bus.mask, key_mask(8'h8D));
    end
    step();
    chk("s gap1", bus.mask, ALL1);
    step();
    chk("s gap2", bus.mask, ALL1);
    chk("s idle busy", bus.busy, 1'b0);

    // FIFO fill with tick stopped: first event is popped, next 16 fill, 18th overflows
    bus.tick = 1'b0;
    for (int i = 0; i < 18; i++) evs[i] = {1'b0, 4'(i % 12), 3'(i % 7)};
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = evs[i];
      step();
      if (i == 15) chk("f not full", bus.full, 1'b0);
      if (i == 16) begin
        chk("f full", bus.full, 1'b1);
        chk("f no ovf yet", bus.overflow, 1'b0);
      end
      if (i == 17) chk("f ovf pulse", bus.overflow, 1'b1);
    end
    bus.wr_en = 1'b0;
    step();
    chk("f ovf clears", bus.overflow, 1'b0);
    chk("f still full", bus.full, 1'b1);
    bus.tick = 1'b1;
    for (int i = 0; i < 17; i++) type_key(evs[i], i > 0, $sformatf("f ev%0d", i));
    repeat (3) step();
    chk("f drained empty", bus.empty, 1'b1);
    chk("f drained busy", bus.busy, 1'b0);
    chk("f dropped absent", bus.mask, ALL1);

    // Bad event 0x67 (row 12, col 7) followed by a valid key
    bus.wr_en = 1'b1; bus.wr_data = 8'h67;
    step();
    bus.wr_data = 8'h0D;
    step();
    bus.wr_en = 1'b0;
    chk("b bad pulse", bus.bad_event, 1'b1);
    chk("b mask", bus.mask, ALL1);
    step();
    chk("b bad one cycle", bus.bad_event, 1'b0);
    chk("b mask2", bus.mask, ALL1);
    type_key(8'h0D, 1'b1, "b next");
    repeat (2) step();

    // Clear during press, with a simultaneous write that must be discarded
    bus.wr_en = 1'b1; bus.wr_data = 8'h0D;
    step();
    bus.wr_data = 8'h00;
    step();
    bus.wr_en = 1'b0;
    step();
    chk("c pressed", bus.mask, key_mask(8'h0D));
    bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h12;
    step();
    bus.clear = 1'b0; bus.wr_en = 1'b0;
    chk("c mask", bus.mask, ALL1);
    chk("c empty", bus.empty, 1'b1);
    chk("c busy", bus.busy, 1'b0);
    ok = 1'b1;
    repeat (6) begin step(); if (bus.mask !== ALL1 || bus.busy !== 1'b0) ok = 1'b0; end
    chk("c stays idle", ok, 1'b1);

    // Reset mid-sequence releases the overlay at once
    bus.wr_en = 1'b1; bus.wr_data = 8'h8D;
    step();
    bus.wr_en = 1'b0;
    step(); step();
    chk("r shift low", bus.mask[6], 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r mask", bus.mask, ALL1);
    chk("r busy", bus.busy, 1'b0);
    chk("r empty", bus.empty, 1'b1);

`ifdef AUTOTYPE_PHYS_PRIORITY_EN
    // Physical key down for 20 ticks during press freezes the hold
    bus.wr_en = 1'b1; bus.wr_data = 8'h0D;
    step();
    bus.wr_en = 1'b0;
    step(); step();
    chk("p pressed", bus.mask, key_mask(8'h0D));
    bus.phys_active = 1'b1;
    ok = 1'b1;
    repeat (20) begin step(); if (bus.mask !== key_mask(8'h0D)) ok = 1'b0; end
    chk("p held", ok, 1'b1);
    bus.phys_active = 1'b0;
    step();
    chk("p rem1", bus.mask, key_mask(8'h0D));
    step();
    chk("p rem2", bus.mask, key_mask(8'h0D));
    step();
    chk("p release", bus.mask, ALL1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
